wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Writeback/commit stage. Drives the register-file write port: regCtrl_wen, regCtrl_rdAddr, rdData and valid.
- Takes completed results from two producers, the EXU (ALU results) and the LSU (load results), over valid/ready handshakes.
- Formats load data, arbitrates between the two producers, and registers the winning write.
- Keeps a 32-entry busy scoreboard so decode can detect RAW hazards on registers whose writes are still pending.

Parameters:
- XLEN, 64, datapath width.
- NREG, 32, number of architectural registers; the index width is log2(NREG) = 5.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode issued an instruction that writes a register.
- issue_rd  in  5  destination register of the issued instruction.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  5  EXU destination register.
- exu_data  in  64  EXU result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  5  load destination register.
- lsu_data  in  64  raw load data, already right-aligned to bit 0.
- lsu_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- lsu_signed  in  1  1 = sign-extend, 0 = zero-extend.
- rs1Addr  in  5  scoreboard query port 1.
- rs2Addr  in  5  scoreboard query port 2.
- rs1_busy  out  1  a write to rs1Addr is pending.
- rs2_busy  out  1  a write to rs2Addr is pending.
- rdData  out  64  write data to the register file.
- regCtrl_wen  out  1  write enable to the register file.
- regCtrl_rdAddr  out  5  write address to the register file.
- valid  out  1  a commit is presented this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - valid, regCtrl_wen, regCtrl_rdAddr and rdData are all 0.
  - Scoreboard busy[31:0] is cleared to 0.
  - Round-robin pointer `last_lsu` is 0, so the LSU wins the first tie.
  - exu_ready and lsu_ready are combinational and are 0 while reset is high.
- Handshake:
  - A transfer occurs when X_valid & X_ready on the same cycle.
  - The output stage never stalls, because the register file always accepts a write. ready is therefore purely the arbitration grant.
  - Producers hold valid and payload stable until ready is seen.
- Arbitration, each cycle:
  - Only one producer valid: that producer is granted.
  - Both valid: grant LSU if last_lsu==0, else grant EXU.
  - last_lsu updates only on a cycle where both producers were valid; it records which one was granted.
  - At most one grant per cycle.
- Load formatting (combinational, before the output register):
  - size 0: bits [7:0] are extended to 64 bits.
  - size 1: bits [15:0] are extended.
  - size 2: bits [31:0] are extended.
  - size 3: the data passes through unchanged.
  - Extension is by sign or zero according to lsu_signed.
  - EXU data passes through unchanged.
- Output register, latency 1 cycle:
  - In the cycle after a grant: valid=1, regCtrl_rdAddr=rd, rdData=formatted data, regCtrl_wen=(rd!=0).
  - A result with rd==0 still commits with valid=1 but with wen=0.
  - With no grant: valid=0 and wen=0. rdData and rdAddr hold their previous values.
  - Back-to-back grants produce back-to-back commits with no bubble.
- Scoreboard:
  - Set: on issue_valid with issue_rd!=0, busy[issue_rd] becomes 1 on the next edge.
  - Clear: on valid & regCtrl_wen, busy[regCtrl_rdAddr] becomes 0 on the next edge.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is hard-wired to 0.
  - rsN_busy = busy[rsNAddr], combinational. Query 0 always returns 0.
- Ordering contract:
  - Decode does not issue to an rd whose bit is already busy (WAW stall is upstream).
  - So at most one write per register is ever in flight.
- Reset mid-operation: pending handshakes are dropped, no commit appears in the cycle after reset, and the scoreboard is cleared.

Optional Feature:
- Macro: WB_COMMIT_TRACE_EN.
- When defined: a DPI-C function `wb_commit_trace(input longint rd, input longint data, input bit wen)` is imported and called at every posedge where valid==1 (not during reset). The simulator uses it for difftest and commit logging.
- When undefined: no DPI import, no extra logic, and behaviour is otherwise identical.

Test Plan:
- Reset release: after reset, valid=0, wen=0, rdData=0, rs1_busy=rs2_busy=0 for all query addresses.
- EXU write: exu_valid, rd=5, data=0x1234 -> exu_ready=1 the same cycle; next cycle valid=1, wen=1, rdAddr=5, rdData=0x1234.
- Load formatting:
  - lsu_data=0x80, size 0, signed=1 -> rdData=0xFFFF_FFFF_FFFF_FF80.
  - Same data with signed=0 -> rdData=0x80.
  - lsu_data=0x8000_0000, size 2, signed=1 -> rdData=0xFFFF_FFFF_8000_0000.
- Arbitration: both producers valid for 4 cycles (EXU rd=1..4, LSU rd=11..14) -> grants alternate LSU, EXU, LSU, EXU. Commits are rd 11, 1, 12, 2 on consecutive cycles.
- Scoreboard:
  - issue rd=7 -> next cycle rs1Addr=7 gives rs1_busy=1.
  - After the commit of rd=7, rs1_busy=0 on the following cycle.
  - issue rd=7 in the same cycle rd=7 commits -> busy stays 1.
  - issue rd=0 -> busy[0] stays 0.
- Zero register: EXU rd=0, data=0xDEAD -> valid=1, wen=0. With WB_COMMIT_TRACE_EN defined, exactly one trace call is made, with wen=0.

Source files
------------

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback arbitration, load formatting and busy scoreboard
module wb_commit_unit #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic                    exu_valid,
  output logic                    exu_ready,
  input  logic [$clog2(NREG)-1:0] exu_rd,
  input  logic [XLEN-1:0]         exu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [$clog2(NREG)-1:0] lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  input  logic [1:0]              lsu_size,
  input  logic                    lsu_signed,
  input  logic [$clog2(NREG)-1:0] rs1Addr,
  input  logic [$clog2(NREG)-1:0] rs2Addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [XLEN-1:0]         rdData,
  output logic                    regCtrl_wen,
  output logic [$clog2(NREG)-1:0] regCtrl_rdAddr,
  output logic                    valid
);
  logic                    last_lsu;
  logic [NREG-1:0]         busy;
  logic [NREG-1:0]         set_mask;
  logic [NREG-1:0]         clr_mask;
  logic                    grant;
  logic                    ext;
  logic [XLEN-1:0]         ld_fmt;
  logic [$clog2(NREG)-1:0] g_rd;
  logic [XLEN-1:0]         g_data;
  always_comb begin
    lsu_ready = !reset && lsu_valid && (!exu_valid || !last_lsu);
    exu_ready = !reset && exu_valid && (!lsu_valid || last_lsu);
    grant     = lsu_ready || exu_ready;
    ext       = lsu_signed && (lsu_size == 2'd0 ? lsu_data[7] :
                               lsu_size == 2'd1 ? lsu_data[15] : lsu_data[31]);
    ld_fmt    = lsu_size == 2'd3 ? lsu_data :
                lsu_size == 2'd2 ? {{(XLEN-32){ext}}, lsu_data[31:0]} :
                lsu_size == 2'd1 ? {{(XLEN-16){ext}}, lsu_data[15:0]} :
                                   {{(XLEN-8){ext}}, lsu_data[7:0]};
    g_rd      = lsu_ready ? lsu_rd : exu_rd;
    g_data    = lsu_ready ? ld_fmt : exu_data;
    set_mask  = (issue_valid && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
    clr_mask  = (valid && regCtrl_wen) ? NREG'(1) << regCtrl_rdAddr : '0;
    rs1_busy  = busy[rs1Addr];
    rs2_busy  = busy[rs2Addr];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid          <= 1'b0;
      regCtrl_wen    <= 1'b0;
      regCtrl_rdAddr <= '0;
      rdData         <= '0;
      last_lsu       <= 1'b0;
      busy           <= '0;
    end else begin
      valid       <= grant;
      regCtrl_wen <= grant && g_rd != '0;
      if (grant) begin
        regCtrl_rdAddr <= g_rd;
        rdData         <= g_data;
      end
      if (exu_valid && lsu_valid)
        last_lsu <= lsu_ready;
      busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed vector table plus hand sequences for arbitration, scoreboard and reset
module tb_wb_commit_unit;
    logic        clock = 0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [1:0]  lsu_size;
    logic        lsu_signed;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [63:0] rdData;
    logic        regCtrl_wen;
    logic [4:0]  regCtrl_rdAddr;
    logic        valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       nm;
        logic        ev;
        logic [4:0]  erd;
        logic [63:0] ed;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic [1:0]  sz;
        logic        sg;
        logic        x_er;
        logic        x_lr;
        logic        x_v;
        logic        x_w;
        logic [4:0]  x_a;
        logic [63:0] x_d;
    } vec_t;

    vec_t tbl[$];

    wb_commit_unit dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_size(lsu_size), .lsu_signed(lsu_signed),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rdData(rdData), .regCtrl_wen(regCtrl_wen), .regCtrl_rdAddr(regCtrl_rdAddr), .valid(valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        issue_valid = 0; exu_valid = 0; lsu_valid = 0;
    endtask

    function automatic void add(input string nm, input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                                input logic [1:0] sz, input logic sg, input logic x_er, input logic x_lr,
                                input logic x_v, input logic x_w, input logic [4:0] x_a, input logic [63:0] x_d);
        vec_t v;
        v.nm = nm; v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.sz = sz; v.sg = sg; v.x_er = x_er; v.x_lr = x_lr; v.x_v = x_v; v.x_w = x_w;
        v.x_a = x_a; v.x_d = x_d;
        tbl.push_back(v);
    endfunction

    task automatic do_reset;
        reset = 1;
        idle();
        step();
        step();
        reset = 0;
    endtask

    initial begin
        logic exp_l;
        logic [4:0] exp_rd;
        int e_i;
        int l_i;
        //   name       ev erd ed                      lv lrd ld                       sz sg  er lr  v  w  a   d
        add("exu5",     1, 5,  64'h1234,               0, 0,  0,                       0, 0,  1, 0,  1, 1, 5,  64'h1234);
        add("lb_s",     0, 0,  0,                      1, 3,  64'h80,                  0, 1,  0, 1,  1, 1, 3,  64'hFFFF_FFFF_FFFF_FF80);
        add("lb_u",     0, 0,  0,                      1, 3,  64'h80,                  0, 0,  0, 1,  1, 1, 3,  64'h80);
        add("lw_s",     0, 0,  0,                      1, 4,  64'h8000_0000,           2, 1,  0, 1,  1, 1, 4,  64'hFFFF_FFFF_8000_0000);
        add("lh_s",     0, 0,  0,                      1, 6,  64'h1234_8000,           1, 1,  0, 1,  1, 1, 6,  64'hFFFF_FFFF_FFFF_8000);
        add("lh_s_pos", 0, 0,  0,                      1, 6,  64'hFFFF_FFFF_FFFF_7FFF, 1, 1,  0, 1,  1, 1, 6,  64'h7FFF);
        add("ld_pass",  0, 0,  0,                      1, 9,  64'h8000_0000_0000_0001, 3, 1,  0, 1,  1, 1, 9,  64'h8000_0000_0000_0001);
        add("lw_u",     0, 0,  0,                      1, 10, 64'h0000_00AB_8000_0000, 2, 0,  0, 1,  1, 1, 10, 64'h8000_0000);
        add("exu_r0",   1, 0,  64'hDEAD,               0, 0,  0,                       0, 0,  1, 0,  1, 0, 0,  64'hDEAD);
        add("idle",     0, 0,  0,                      0, 0,  0,                       0, 0,  0, 0,  0, 0, 0,  64'hDEAD);
        add("lb_u31",   0, 0,  0,                      1, 31, 64'hABCD,                0, 0,  0, 1,  1, 1, 31, 64'hCD);

        issue_rd = 0; exu_rd = 0; exu_data = 0; lsu_rd = 0; lsu_data = 0;
        lsu_size = 0; lsu_signed = 0; rs1Addr = 0; rs2Addr = 0;
        reset = 1;
        idle();
        step();
        exu_valid = 1; lsu_valid = 1;
        #1;
        chk("rst_exu_ready", 64'(exu_ready), 0);
        chk("rst_lsu_ready", 64'(lsu_ready), 0);
        step();
        idle();
        reset = 0;
        #1;
        chk("rst_valid", 64'(valid), 0);
        chk("rst_wen", 64'(regCtrl_wen), 0);
        chk("rst_rdData", rdData, 0);
        chk("rst_rdAddr", 64'(regCtrl_rdAddr), 0);
        for (int i = 0; i < 32; i++) begin
            rs1Addr = 5'(i); rs2Addr = 5'(31 - i);
            #1;
            chk("rst_rs1_busy", 64'(rs1_busy), 0);
            chk("rst_rs2_busy", 64'(rs2_busy), 0);
        end

        foreach (tbl[i]) begin
            exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            lsu_size = tbl[i].sz; lsu_signed = tbl[i].sg;
            #1;
            chk({tbl[i].nm, "_exu_ready"}, 64'(exu_ready), 64'(tbl[i].x_er));
            chk({tbl[i].nm, "_lsu_ready"}, 64'(lsu_ready), 64'(tbl[i].x_lr));
            step();
            idle();
            chk({tbl[i].nm, "_valid"}, 64'(valid), 64'(tbl[i].x_v));
            chk({tbl[i].nm, "_wen"}, 64'(regCtrl_wen), 64'(tbl[i].x_w));
            if (tbl[i].x_v) chk({tbl[i].nm, "_rdAddr"}, 64'(regCtrl_rdAddr), 64'(tbl[i].x_a));
            chk({tbl[i].nm, "_rdData"}, rdData, tbl[i].x_d);
        end

        // Arbitration: fresh reset so last_lsu starts at 0 (LSU first).
        do_reset();
        e_i = 0; l_i = 0;
        exu_valid = 1; lsu_valid = 1; lsu_size = 3; lsu_signed = 0;
        for (int c = 0; c < 4; c++) begin
            exu_rd = 5'(1 + e_i); exu_data = 64'(100 + e_i);
            lsu_rd = 5'(11 + l_i); lsu_data = 64'(200 + l_i);
            exp_l = (c % 2 == 0);
            exp_rd = exp_l ? 5'(11 + l_i) : 5'(1 + e_i);
            #1;
            chk("arb_lsu_ready", 64'(lsu_ready), 64'(exp_l));
            chk("arb_exu_ready", 64'(exu_ready), 64'(!exp_l));
            step();
            chk("arb_valid", 64'(valid), 1);
            chk("arb_rdAddr", 64'(regCtrl_rdAddr), 64'(exp_rd));
            chk("arb_rdData", rdData, exp_l ? 64'(200 + l_i) : 64'(100 + e_i));
            if (exp_l) l_i++; else e_i++;
        end
        // Last tie went to EXU; a lone EXU grant must not move the pointer.
        lsu_valid = 0;
        exu_rd = 5'd20;
        step();
        chk("lone_exu_rdAddr", 64'(regCtrl_rdAddr), 20);
        lsu_valid = 1; lsu_rd = 5'd21; exu_rd = 5'd22;
        #1;
        chk("tie_after_lone_lsu", 64'(lsu_ready), 1);
        step();
        chk("tie_after_lone_rdAddr", 64'(regCtrl_rdAddr), 21);
        idle();
        step();
        chk("arb_drain_valid", 64'(valid), 0);

        // Scoreboard set / clear / same-cycle set-wins / rd0.
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0; rs1Addr = 7; rs2Addr = 7;
        #1;
        chk("sb_set_rs1", 64'(rs1_busy), 1);
        chk("sb_set_rs2", 64'(rs2_busy), 1);
        exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
        step();
        exu_valid = 0;
        chk("sb_commit_valid", 64'(valid & regCtrl_wen), 1);
        chk("sb_busy_during_commit", 64'(rs1_busy), 1);
        step();
        chk("sb_cleared", 64'(rs1_busy), 0);
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        exu_valid = 1; exu_rd = 7;
        step();
        exu_valid = 0;
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        chk("sb_set_wins", 64'(rs1_busy), 1);
        issue_valid = 1; issue_rd = 0;
        rs1Addr = 0; rs2Addr = 8;
        step();
        issue_valid = 0;
        chk("sb_rd0", 64'(rs1_busy), 0);
        chk("sb_other_idle", 64'(rs2_busy), 0);

        // Reset mid-operation.
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0; rs1Addr = 9;
        #1;
        chk("mid_busy_set", 64'(rs1_busy), 1);
        exu_valid = 1; exu_rd = 9; reset = 1;
        #1;
        chk("mid_exu_ready", 64'(exu_ready), 0);
        step();
        reset = 0; exu_valid = 0;
        #1;
        chk("mid_valid", 64'(valid), 0);
        chk("mid_busy_clr", 64'(rs1_busy), 0);
        chk("mid_rs7_clr", 64'(dut.busy[7]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
